// File: rtl/dds_param_ctrl_if.sv
// Byte-stream link between the UART and the DDS parameter controller:
// received command bytes in, one ACK/NAK byte per frame out.
interface dds_param_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       ack_valid;
    logic [7:0] ack_byte;

    modport master (
        output rx_data,
        output rx_valid,
        input  ack_valid,
        input  ack_byte
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output ack_valid,
        output ack_byte
    );
endinterface

// File: rtl/dds_param_ctrl.sv
// Frame parser for DDS configuration: validates each command frame and applies its
// fields to the dds top atomically, answering every frame with one ACK/NAK byte.
module dds_param_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 50_000,
    parameter logic [5:0]  DEF_WAVE    = 6'd1,
    parameter logic [3:0]  DEF_MODE    = 4'd1,
    parameter logic [8:0]  DEF_F       = 9'd50,
    parameter logic [10:0] DEF_T       = 11'd100,
    parameter logic [6:0]  DEF_Z       = 7'd10
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    dds_param_ctrl_if.slave  bus,
    output logic [5:0]       wave_sel,
    output logic [3:0]       mode_sel,
    output logic [8:0]       F,
    output logic [10:0]      T,
    output logic [6:0]       Z,
    output logic             cfg_upd
);

    localparam int unsigned       GapW    = $clog2(TIMEOUT_CYC);
    localparam logic [GapW-1:0]   GapLast = GapW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCmd  = 2'd1;
    localparam logic [1:0] StData = 2'd2;
    localparam logic [1:0] StChk  = 2'd3;

    localparam logic [7:0] Sync    = 8'hA5;
    localparam logic [7:0] CmdF    = 8'h01;
    localparam logic [7:0] CmdT    = 8'h02;
    localparam logic [7:0] CmdZ    = 8'h03;
    localparam logic [7:0] CmdWave = 8'h04;
    localparam logic [7:0] CmdMode = 8'h05;
    localparam logic [7:0] CmdAll  = 8'h10;

    localparam logic [7:0] AckOk      = 8'h5A;
    localparam logic [7:0] AckBadChk  = 8'hE1;
    localparam logic [7:0] AckBadCmd  = 8'hE2;
    localparam logic [7:0] AckRange   = 8'hE3;
    localparam logic [7:0] AckTimeout = 8'hE4;

    logic [1:0]      state_q, state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic            bad_cmd_q, bad_cmd_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      acc_q, acc_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [8:0]      sh_f_q, sh_f_d;
    logic [10:0]     sh_t_q, sh_t_d;
    logic [6:0]      sh_z_q, sh_z_d;
    logic [5:0]      sh_w_q, sh_w_d;
    logic [3:0]      sh_m_q, sh_m_d;
    logic            ack_valid_q, ack_valid_d;
    logic [7:0]      ack_byte_q, ack_byte_d;
    logic            cfg_upd_q;
    logic            apply;

    logic [5:0]      wave_q;
    logic [3:0]      mode_q;
    logic [8:0]      f_q;
    logic [10:0]     t_q;
    logic [6:0]      z_q;

    logic [2:0]      cmd_len;
    logic            is_all;
    logic            f_ok, t_ok, z_ok, range_ok;

    always_comb begin
        cmd_len = 3'd0;
        case (bus.rx_data)
            CmdF, CmdT:       cmd_len = 3'd2;
            CmdZ, CmdWave,
            CmdMode:          cmd_len = 3'd1;
            CmdAll:           cmd_len = 3'd7;
            default:          cmd_len = 3'd0;
        endcase
    end

    assign is_all = (cmd_q == CmdAll);
    assign f_ok   = (sh_f_q != 9'd0) && (sh_f_q <= 9'd500);
    assign t_ok   = (sh_t_q != 11'd0);
    assign z_ok   = (sh_z_q != 7'd0) && (sh_z_q <= 7'd100);

    always_comb begin
        range_ok = 1'b1;
        case (cmd_q)
            CmdF:    range_ok = f_ok;
            CmdT:    range_ok = t_ok;
            CmdZ:    range_ok = z_ok;
            CmdAll:  range_ok = f_ok && t_ok && z_ok;
            default: range_ok = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        bad_cmd_d   = bad_cmd_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        gap_d       = '0;
        sh_f_d      = sh_f_q;
        sh_t_d      = sh_t_q;
        sh_z_d      = sh_z_q;
        sh_w_d      = sh_w_q;
        sh_m_d      = sh_m_q;
        ack_valid_d = 1'b0;
        ack_byte_d  = ack_byte_q;
        apply       = 1'b0;

        if (state_q != StIdle && !bus.rx_valid) begin
            gap_d = gap_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (bus.rx_valid && bus.rx_data == Sync) begin
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (bus.rx_valid) begin
                    cmd_d     = bus.rx_data;
                    acc_d     = bus.rx_data;
                    cnt_d     = cmd_len;
                    bad_cmd_d = (cmd_len == 3'd0);
                    // Unknown commands carry no payload; the next byte is taken as CHK.
                    state_d   = (cmd_len == 3'd0) ? StChk : StData;
                end
            end
            StData: begin
                if (bus.rx_valid) begin
                    acc_d = acc_q + bus.rx_data;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = StChk;
                    end
                    // Byte position is identified by the remaining count (payload is MSB first).
                    if ((cmd_q == CmdF && cnt_q == 3'd2) || (is_all && cnt_q == 3'd7)) begin
                        sh_f_d[8] = bus.rx_data[0];
                    end
                    if ((cmd_q == CmdF && cnt_q == 3'd1) || (is_all && cnt_q == 3'd6)) begin
                        sh_f_d[7:0] = bus.rx_data;
                    end
                    if ((cmd_q == CmdT && cnt_q == 3'd2) || (is_all && cnt_q == 3'd5)) begin
                        sh_t_d[10:8] = bus.rx_data[2:0];
                    end
                    if ((cmd_q == CmdT && cnt_q == 3'd1) || (is_all && cnt_q == 3'd4)) begin
                        sh_t_d[7:0] = bus.rx_data;
                    end
                    if ((cmd_q == CmdZ && cnt_q == 3'd1) || (is_all && cnt_q == 3'd3)) begin
                        sh_z_d = bus.rx_data[6:0];
                    end
                    if ((cmd_q == CmdWave && cnt_q == 3'd1) || (is_all && cnt_q == 3'd2)) begin
                        sh_w_d = bus.rx_data[5:0];
                    end
                    if ((cmd_q == CmdMode && cnt_q == 3'd1) || (is_all && cnt_q == 3'd1)) begin
                        sh_m_d = bus.rx_data[3:0];
                    end
                end
            end
            default: begin
                if (bus.rx_valid) begin
                    state_d     = StIdle;
                    ack_valid_d = 1'b1;
                    if (bad_cmd_q) begin
                        ack_byte_d = AckBadCmd;
                    end else if (acc_q != bus.rx_data) begin
                        ack_byte_d = AckBadChk;
                    end else if (!range_ok) begin
                        ack_byte_d = AckRange;
                    end else begin
                        ack_byte_d = AckOk;
                        apply      = 1'b1;
                    end
                end
            end
        endcase

        // A byte arriving in the last allowed cycle takes priority over the timeout.
        if (state_q != StIdle && !bus.rx_valid && gap_q == GapLast) begin
            state_d     = StIdle;
            gap_d       = '0;
            ack_valid_d = 1'b1;
            ack_byte_d  = AckTimeout;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            bad_cmd_q   <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            gap_q       <= '0;
            sh_f_q      <= '0;
            sh_t_q      <= '0;
            sh_z_q      <= '0;
            sh_w_q      <= '0;
            sh_m_q      <= '0;
            ack_valid_q <= 1'b0;
            ack_byte_q  <= '0;
            cfg_upd_q   <= 1'b0;
            wave_q      <= DEF_WAVE;
            mode_q      <= DEF_MODE;
            f_q         <= DEF_F;
            t_q         <= DEF_T;
            z_q         <= DEF_Z;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            bad_cmd_q   <= bad_cmd_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            gap_q       <= gap_d;
            sh_f_q      <= sh_f_d;
            sh_t_q      <= sh_t_d;
            sh_z_q      <= sh_z_d;
            sh_w_q      <= sh_w_d;
            sh_m_q      <= sh_m_d;
            ack_valid_q <= ack_valid_d;
            ack_byte_q  <= ack_byte_d;
            cfg_upd_q   <= apply;
            if (apply) begin
                case (cmd_q)
                    CmdF:    f_q    <= sh_f_q;
                    CmdT:    t_q    <= sh_t_q;
                    CmdZ:    z_q    <= sh_z_q;
                    CmdWave: wave_q <= sh_w_q;
                    CmdMode: mode_q <= sh_m_q;
                    CmdAll: begin
                        f_q    <= sh_f_q;
                        t_q    <= sh_t_q;
                        z_q    <= sh_z_q;
                        wave_q <= sh_w_q;
                        mode_q <= sh_m_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wave_sel      = wave_q;
    assign mode_sel      = mode_q;
    assign F             = f_q;
    assign T             = t_q;
    assign Z             = z_q;
    assign cfg_upd       = cfg_upd_q;
    assign bus.ack_valid = ack_valid_q;
    assign bus.ack_byte  = ack_byte_q;

endmodule

// File: tb/tb_dds_param_ctrl.sv
// Directed bench for dds_param_ctrl: table of framed commands with expected ACKs and
// resulting configuration, plus timeout, reset and bad-command sequences.
module tb_dds_param_ctrl;

    localparam int unsigned TO = 20;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [5:0]  wave_sel;
    logic [3:0]  mode_sel;
    logic [8:0]  F;
    logic [10:0] T;
    logic [6:0]  Z;
    logic        cfg_upd;

    dds_param_ctrl_if bus ();

    dds_param_ctrl #(
        .TIMEOUT_CYC (TO)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus),
        .wave_sel  (wave_sel),
        .mode_sel  (mode_sel),
        .F         (F),
        .T         (T),
        .Z         (Z),
        .cfg_upd   (cfg_upd)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [79:0] frame;
        int          n;
        logic [7:0]  ack;
        logic        upd;
        logic [8:0]  f;
        logic [10:0] t;
        logic [6:0]  z;
        logic [5:0]  w;
        logic [3:0]  m;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_fail   = 0;
    int frame_acks;
    int frame_upds;
    logic [7:0] last_ack;
    int stuck = 0;
    logic prev_ack = 1'b0;
    logic prev_upd = 1'b0;

    always @(negedge sys_clk) begin
        if (bus.ack_valid && prev_ack) stuck++;
        if (cfg_upd && prev_upd) stuck++;
        prev_ack = bus.ack_valid;
        prev_upd = cfg_upd;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic observe();
        if (bus.ack_valid) begin
            frame_acks++;
            last_ack = bus.ack_byte;
        end
        if (cfg_upd) frame_upds++;
    endtask

    // Byte is sampled at the next rising edge; returns 2 time units after that edge.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge sys_clk);
        #2;
        bus.rx_valid = 1'b0;
        observe();
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge sys_clk);
            #2;
            observe();
        end
    endtask

    task automatic check_cfg(input string tag, input logic [8:0] f, input logic [10:0] t,
                             input logic [6:0] z, input logic [5:0] w, input logic [3:0] m);
        check({tag, " F"}, F, f);
        check({tag, " T"}, T, t);
        check({tag, " Z"}, Z, z);
        check({tag, " wave"}, wave_sel, w);
        check({tag, " mode"}, mode_sel, m);
    endtask

    initial begin
        vecs[0]  = '{80'hA501006465,         5, 8'h5A, 1'b1, 9'd100, 11'd100,  7'd10,  6'd1,  4'd1};
        vecs[1]  = '{80'hA5036568,           4, 8'hE3, 1'b0, 9'd100, 11'd100,  7'd10,  6'd1,  4'd1};
        vecs[2]  = '{80'hA501006466,         5, 8'hE1, 1'b0, 9'd100, 11'd100,  7'd10,  6'd1,  4'd1};
        vecs[3]  = '{80'hA51001F407FF640203F7, 10, 8'hE1, 1'b0, 9'd100, 11'd100, 7'd10, 6'd1, 4'd1};
        vecs[4]  = '{80'hA51001F407FF64020374, 10, 8'h5A, 1'b1, 9'd500, 11'd2047, 7'd100, 6'd2, 4'd3};
        vecs[5]  = '{80'hA51001F40000640203_6E, 10, 8'hE3, 1'b0, 9'd500, 11'd2047, 7'd100, 6'd2, 4'd3};
        vecs[6]  = '{80'hA502000002,         5, 8'hE3, 1'b0, 9'd500, 11'd2047, 7'd100, 6'd2,  4'd3};
        vecs[7]  = '{80'hA504FF03,           4, 8'h5A, 1'b1, 9'd500, 11'd2047, 7'd100, 6'd63, 4'd3};
        vecs[8]  = '{80'hA505090E,           4, 8'h5A, 1'b1, 9'd500, 11'd2047, 7'd100, 6'd63, 4'd9};
        vecs[9]  = '{80'hA5030003,           4, 8'hE3, 1'b0, 9'd500, 11'd2047, 7'd100, 6'd63, 4'd9};
        vecs[10] = '{80'hA50101F5F7,         5, 8'hE3, 1'b0, 9'd500, 11'd2047, 7'd100, 6'd63, 4'd9};
        vecs[11] = '{80'hA50101F4F6,         5, 8'h5A, 1'b1, 9'd500, 11'd2047, 7'd100, 6'd63, 4'd9};
        vecs[12] = '{80'hA502F801FB,         5, 8'h5A, 1'b1, 9'd500, 11'd1,   7'd100, 6'd63, 4'd9};
        vecs[13] = '{80'hA503B2B5,           4, 8'h5A, 1'b1, 9'd500, 11'd1,   7'd50,  6'd63, 4'd9};
        vecs[14] = '{80'hA501000102,         5, 8'h5A, 1'b1, 9'd1,   11'd1,   7'd50,  6'd63, 4'd9};

        sys_rst_n    = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        #2;
        check_cfg("reset", 9'd50, 11'd100, 7'd10, 6'd1, 4'd1);
        check("reset cfg_upd", cfg_upd, 1'b0);
        check("reset ack_valid", bus.ack_valid, 1'b0);
        check("reset ack_byte", bus.ack_byte, 8'h00);
        sys_rst_n = 1'b1;
        idle(2);

        for (int k = 0; k < NV; k++) begin
            frame_acks = 0;
            frame_upds = 0;
            for (int i = 0; i < vecs[k].n; i++) begin
                send_byte(vecs[k].frame[8*(vecs[k].n-1-i) +: 8]);
            end
            check($sformatf("v%0d ack_valid", k), bus.ack_valid, 1'b1);
            check($sformatf("v%0d ack_byte", k), bus.ack_byte, vecs[k].ack);
            check($sformatf("v%0d cfg_upd", k), cfg_upd, vecs[k].upd);
            check($sformatf("v%0d ack count", k), frame_acks, 1);
            check($sformatf("v%0d upd count", k), frame_upds, {31'd0, vecs[k].upd});
            check_cfg($sformatf("v%0d", k), vecs[k].f, vecs[k].t, vecs[k].z, vecs[k].w, vecs[k].m);
            idle(1);
            check($sformatf("v%0d ack_valid drop", k), bus.ack_valid, 1'b0);
            check($sformatf("v%0d cfg_upd drop", k), cfg_upd, 1'b0);
        end

        // Gap timeout after a partial frame
        frame_acks = 0;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        idle(TO - 1);
        check("timeout early", frame_acks, 0);
        idle(1);
        check("timeout ack_valid", bus.ack_valid, 1'b1);
        check("timeout ack_byte", bus.ack_byte, 8'hE4);
        check("timeout no upd", cfg_upd, 1'b0);
        check_cfg("timeout", 9'd1, 11'd1, 7'd50, 6'd63, 4'd9);
        frame_acks = 0;
        frame_upds = 0;
        send_byte(8'hA5);
        send_byte(8'h05);
        send_byte(8'h02);
        send_byte(8'h07);
        check("post-timeout ack", last_ack, 8'h5A);
        check("post-timeout ack count", frame_acks, 1);
        check("post-timeout mode", mode_sel, 4'd2);

        // Bytes landing exactly in the last allowed cycle keep the frame alive
        frame_acks = 0;
        send_byte(8'hA5);
        send_byte(8'h05);
        idle(TO - 1);
        send_byte(8'h04);
        idle(TO - 1);
        send_byte(8'h09);
        check("edge gap ack count", frame_acks, 1);
        check("edge gap ack", last_ack, 8'h5A);
        check("edge gap mode", mode_sel, 4'd4);

        // Reset mid-frame discards the partial frame
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        sys_rst_n = 1'b0;
        #3;
        check_cfg("mid reset", 9'd50, 11'd100, 7'd10, 6'd1, 4'd1);
        @(posedge sys_clk);
        #2;
        sys_rst_n  = 1'b1;
        frame_acks = 0;
        send_byte(8'h64);
        send_byte(8'h65);
        idle(2);
        check("orphan bytes no ack", frame_acks, 0);
        check("orphan bytes F", F, 9'd50);

        frame_acks = 0;
        send_byte(8'hA5);
        send_byte(8'h77);
        send_byte(8'hC3);
        send_byte(8'h77);
        idle(2);
        check("bad cmd ack count", frame_acks, 1);
        check("bad cmd ack", last_ack, 8'hE2);

        frame_acks = 0;
        send_byte(8'h33);
        idle(3);
        check("stray byte no ack", frame_acks, 0);
        check_cfg("final", 9'd50, 11'd100, 7'd10, 6'd1, 4'd1);

        check("pulse width", stuck, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
